// File: rtl/game_pkg.sv
// Shared game types: state encoding and BCD digit, also used by the renderer.
package game_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StPlay  = 3'd1,
        StDying = 3'd2,
        StOver  = 3'd3
    } game_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int unsigned ScoreDigits = 3;

    function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Handshake bundle between the game flow controller and the rest of the game.
interface game_flow_ctrl_if;

    logic                  frame_tick;
    logic                  flap_req;
    logic                  jb0;
    logic                  collision;
    logic                  pipe_pass;
    game_pkg::game_state_t state;
    logic                  world_en;
    logic                  bird_en;
    logic                  flap_evt;
    logic                  new_game;
    logic [11:0]           score;
    logic [11:0]           best;

    modport master (
        output frame_tick, flap_req, jb0, collision, pipe_pass,
        input  state, world_en, bird_en, flap_evt, new_game, score, best
    );

    modport slave (
        input  frame_tick, flap_req, jb0, collision, pipe_pass,
        output state, world_en, bird_en, flap_evt, new_game, score, best
    );

endinterface

// File: rtl/bcd_score_cnt.sv
// Three-digit BCD score counter with synchronous clear and saturation at 999.
module bcd_score_cnt
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [11:0] score
);

    bcd_digit_t [ScoreDigits-1:0] dig_q, dig_d;

    always_comb begin
        dig_d = dig_q;
        if (clr) begin
            dig_d = '0;
        end else if (inc && (dig_q != 12'h999)) begin
            dig_d[0] = bcd_inc(dig_q[0]);
            if (dig_q[0] == 4'd9) begin
                dig_d[1] = bcd_inc(dig_q[1]);
                if (dig_q[1] == 4'd9) begin
                    dig_d[2] = bcd_inc(dig_q[2]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q <= '0;
        end else begin
            dig_q <= dig_d;
        end
    end

    assign score = dig_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow FSM: IDLE/PLAY/DYING/OVER sequencing, frame-aligned flap, score and best.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned DEATH_FRAMES     = 60,
    parameter int unsigned OVER_LOCK_FRAMES = 30
) (
    input logic             clk,
    input logic             rst_n,
    game_flow_ctrl_if.slave bus
);

    localparam logic [7:0] DeathLast = 8'(DEATH_FRAMES - 1);
    localparam logic [7:0] OverLock  = 8'(OVER_LOCK_FRAMES);

    logic        jb0_s1_q, jb0_s2_q, jb0_s3_q;
    logic        jb0_rise, flap_src, flap_now;
    logic        flap_pending_q;
    game_state_t state_q;
    logic [7:0]  frame_cnt_q, frame_cnt_inc;
    logic        new_game_q;
    logic [11:0] best_q;
    logic [11:0] score;

    assign jb0_rise      = jb0_s2_q & ~jb0_s3_q;
    assign flap_src      = bus.flap_req | jb0_rise;
    // A flap arriving on the tick cycle itself belongs to that frame.
    assign flap_now      = flap_pending_q | flap_src;
    assign frame_cnt_inc = (frame_cnt_q == 8'hff) ? 8'hff : frame_cnt_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jb0_s1_q       <= 1'b0;
            jb0_s2_q       <= 1'b0;
            jb0_s3_q       <= 1'b0;
            flap_pending_q <= 1'b0;
        end else begin
            jb0_s1_q <= bus.jb0;
            jb0_s2_q <= jb0_s1_q;
            jb0_s3_q <= jb0_s2_q;
            if (bus.frame_tick) begin
                flap_pending_q <= 1'b0;
            end else if (flap_src) begin
                flap_pending_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            frame_cnt_q <= 8'd0;
            new_game_q  <= 1'b0;
            best_q      <= 12'h000;
        end else begin
            new_game_q <= 1'b0;
            if (bus.frame_tick) begin
                frame_cnt_q <= frame_cnt_inc;
                case (state_q)
                    StIdle: begin
                        if (flap_now) begin
                            state_q     <= StPlay;
                            new_game_q  <= 1'b1;
                            frame_cnt_q <= 8'd0;
                        end
                    end
                    StPlay: begin
                        if (bus.collision) begin
                            state_q     <= StDying;
                            frame_cnt_q <= 8'd0;
                        end
                    end
                    StDying: begin
                        if (frame_cnt_q >= DeathLast) begin
                            state_q     <= StOver;
                            frame_cnt_q <= 8'd0;
                            // Packed BCD orders the same as its decimal value.
                            if (score > best_q) begin
                                best_q <= score;
                            end
                        end
                    end
                    StOver: begin
                        if (flap_now && (frame_cnt_q >= OverLock)) begin
                            state_q     <= StPlay;
                            new_game_q  <= 1'b1;
                            frame_cnt_q <= 8'd0;
                        end
                    end
                    default: begin
                        state_q     <= StIdle;
                        frame_cnt_q <= 8'd0;
                    end
                endcase
            end
        end
    end

    bcd_score_cnt u_score (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (new_game_q),
        .inc   (bus.pipe_pass && (state_q == StPlay)),
        .score (score)
    );

    assign bus.state    = state_q;
    assign bus.world_en = (state_q == StPlay);
    assign bus.bird_en  = (state_q == StPlay) || (state_q == StDying);
    assign bus.flap_evt = bus.frame_tick && flap_now && (state_q == StPlay);
    assign bus.new_game = new_game_q;
    assign bus.score    = score;
    assign bus.best     = best_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: vector table plus multi-cycle sequences.
module tb_game_flow_ctrl;

    localparam logic [2:0] SIdle  = 3'd0;
    localparam logic [2:0] SPlay  = 3'd1;
    localparam logic [2:0] SDying = 3'd2;
    localparam logic [2:0] SOver  = 3'd3;
    localparam int NV = 19;

    typedef struct packed {
        logic        ft;
        logic        fr;
        logic        col;
        logic        pp;
        logic [2:0]  st;
        logic        we;
        logic        be;
        logic        ng;
        logic        fe;
        logic [11:0] sc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic evt_seen;
    int   checks = 0;
    int   errors = 0;
    int   n;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    game_flow_ctrl_if bus ();

    game_flow_ctrl #(
        .DEATH_FRAMES     (60),
        .OVER_LOCK_FRAMES (30)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample flap_evt mid-cycle, settle after the edge.
    task automatic cyc(input logic t, input logic f, input logic c, input logic p);
        bus.frame_tick = t;
        bus.flap_req   = f;
        bus.collision  = c;
        bus.pipe_pass  = p;
        @(negedge clk);
        evt_seen = bus.flap_evt;
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        bus.flap_req   = 1'b0;
        bus.collision  = 1'b0;
        bus.pipe_pass  = 1'b0;
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.flap_req   = 1'b0;
        bus.jb0        = 1'b0;
        bus.collision  = 1'b0;
        bus.pipe_pass  = 1'b0;

        //           ft    fr    col   pp    st      we    be    ng    fe    score
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, SIdle,  1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, SIdle,  1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, SIdle,  1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, SPlay,  1'b1, 1'b1, 1'b1, 1'b0, 12'h000};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, SPlay,  1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, SPlay,  1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, SPlay,  1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, SPlay,  1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, SPlay,  1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, SPlay,  1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, SPlay,  1'b1, 1'b1, 1'b0, 1'b1, 12'h000};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, SPlay,  1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, SPlay,  1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, SPlay,  1'b1, 1'b1, 1'b0, 1'b1, 12'h000};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, SPlay,  1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, SPlay,  1'b1, 1'b1, 1'b0, 1'b1, 12'h000};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, SPlay,  1'b1, 1'b1, 1'b0, 1'b0, 12'h001};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, SPlay,  1'b1, 1'b1, 1'b0, 1'b0, 12'h002};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b1, SPlay,  1'b1, 1'b1, 1'b0, 1'b0, 12'h003};

        repeat (3) @(posedge clk);
        #1;
        chk("reset state", 12'(bus.state), 12'(SIdle));
        chk("reset score", bus.score, 12'h000);
        chk("reset best", bus.best, 12'h000);
        chk("reset new_game", 12'(bus.new_game), 12'h0);
        chk("reset world_en", 12'(bus.world_en), 12'h0);
        chk("reset bird_en", 12'(bus.bird_en), 12'h0);
        chk("reset flap_evt", 12'(bus.flap_evt), 12'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            cyc(vecs[i].ft, vecs[i].fr, vecs[i].col, vecs[i].pp);
            chk($sformatf("vec%0d state", i), 12'(bus.state), 12'(vecs[i].st));
            chk($sformatf("vec%0d world_en", i), 12'(bus.world_en), 12'(vecs[i].we));
            chk($sformatf("vec%0d bird_en", i), 12'(bus.bird_en), 12'(vecs[i].be));
            chk($sformatf("vec%0d new_game", i), 12'(bus.new_game), 12'(vecs[i].ng));
            chk($sformatf("vec%0d flap_evt", i), 12'(evt_seen), 12'(vecs[i].fe));
            chk($sformatf("vec%0d score", i), bus.score, vecs[i].sc);
        end

        // Reach 012 with the last pipe_pass on the collision tick.
        repeat (8) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("score carry 011", bus.score, 12'h011);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("dying state", 12'(bus.state), 12'(SDying));
        chk("dying score", bus.score, 12'h012);
        chk("dying world_en", 12'(bus.world_en), 12'h0);
        chk("dying bird_en", 12'(bus.bird_en), 12'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("dying pipe ignored", bus.score, 12'h012);
        repeat (59) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("dying after 59", 12'(bus.state), 12'(SDying));
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("over after 60", 12'(bus.state), 12'(SOver));
        chk("best 012", bus.best, 12'h012);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("over pipe ignored", bus.score, 12'h012);

        // OVER lock: flap on tick 10 rejected, on tick 31 accepted.
        repeat (9) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("over flap at 10", 12'(bus.state), 12'(SOver));
        repeat (20) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("over at 30", 12'(bus.state), 12'(SOver));
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("restart state", 12'(bus.state), 12'(SPlay));
        chk("restart new_game", 12'(bus.new_game), 12'h1);
        chk("restart flap_evt", 12'(evt_seen), 12'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart score", bus.score, 12'h000);
        chk("restart best", bus.best, 12'h012);
        chk("restart new_game off", 12'(bus.new_game), 12'h0);

        repeat (998) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("score 998", bus.score, 12'h998);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("score sat 999", bus.score, 12'h999);

        // jb0 held high: only its rising edge flaps.
        n = 0;
        bus.jb0 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            cyc(((i % 50) == 49), 1'b0, 1'b0, 1'b0);
            n += int'(evt_seen);
        end
        bus.jb0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(((i % 5) == 4), 1'b0, 1'b0, 1'b0);
            n += int'(evt_seen);
        end
        chk("jb0 held flaps", 12'(n), 12'd1);

        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (60) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("second over", 12'(bus.state), 12'(SOver));
        chk("best 999", bus.best, 12'h999);

        repeat (30) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("third play", 12'(bus.state), 12'(SPlay));
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("third dying", 12'(bus.state), 12'(SDying));
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-DYING.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst state", 12'(bus.state), 12'(SIdle));
        chk("async rst score", bus.score, 12'h000);
        chk("async rst best", bus.best, 12'h000);
        chk("async rst bird_en", 12'(bus.bird_en), 12'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            n += int'(bus.new_game);
        end
        chk("no new_game after rst", 12'(n), 12'd0);
        chk("idle after rst", 12'(bus.state), 12'(SIdle));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter DEATH_FRAMES, default 60, frames spent in DYING.
REQ-002 SHALL have parameter OVER_LOCK_FRAMES, default 30, frames in OVER before a restart is accepted.
REQ-003 SHALL have ports:
  clk  input  1  pixel clock (65 MHz), the single clock
  rst_n  input  1  asynchronous active-low reset
  frame_tick  input  1  one-cycle pulse per frame at vblank start
  flap_req  input  1  one-cycle pulse from the PS/2 key decoder
  jb0  input  1  raw external button, asynchronous
  collision  input  1  level from the collision detector, valid at frame_tick
  pipe_pass  input  1  one-cycle pulse when the bird clears a pipe
  state  output  3  current game_state_t
  world_en  output  1  pipe/background scroll enable
  bird_en  output  1  bird physics enable
  flap_evt  output  1  one-cycle, frame-aligned flap command
  new_game  output  1  one-cycle pulse; clears bird, pipes and score
  score  output  12  3-digit BCD current score
  best  output  12  3-digit BCD best score

Function
REQ-004 SHALL synchronise jb0 through two flip-flops and rising-edge detect it; flap_src = flap_req OR jb0 rising edge.
REQ-005 SHALL set flap_pending on flap_src and clear it on frame_tick; flap_src on the same cycle as frame_tick counts for that frame.
REQ-006 SHALL assert flap_evt for exactly the frame_tick cycle when (flap_pending OR flap_src) and state is PLAY; otherwise flap_evt = 0.
REQ-007 SHALL use states IDLE, PLAY, DYING, OVER; all transitions occur only on frame_tick cycles, registered (outputs change the cycle after).
REQ-008 IDLE -> PLAY on frame_tick with pending flap; new_game pulses the same cycle as the transition registers; that flap does not produce flap_evt.
REQ-009 PLAY -> DYING on frame_tick with collision = 1; frame counter loads 0.
REQ-010 DYING -> OVER after DEATH_FRAMES frame_ticks; best updated to score in the cycle of this transition if score > best.
REQ-011 OVER -> PLAY on frame_tick with pending flap, only when at least OVER_LOCK_FRAMES frame_ticks have elapsed in OVER; flaps earlier are discarded (pending cleared at each frame_tick) and new_game pulses on transition.
REQ-012 world_en = 1 only in PLAY; bird_en = 1 in PLAY and DYING.
REQ-013 score SHALL increment by one BCD step on pipe_pass while in PLAY, with per-digit carry 9 -> 0; saturates at 999.
REQ-014 pipe_pass coinciding with a PLAY -> DYING frame_tick SHALL still count; pipe_pass in any other state is ignored.
REQ-015 new_game SHALL clear score to 000 on the following cycle; best is never cleared except by reset.
REQ-016 Frame counter SHALL be 8 bits wide, saturating, reset on every state change.

Reset
REQ-017 rst_n low SHALL asynchronously force: state IDLE, score 000, best 000, flap_pending 0, counters 0, synchroniser 0, all pulse and enable outputs 0.
REQ-018 Reset asserted mid-PLAY or mid-DYING SHALL return to IDLE with no new_game pulse emitted on release.
REQ-019 Deassertion SHALL be released synchronously by the upstream reset synchroniser; this block assumes nothing else about it.

Structure
REQ-020 game_state_t enum (IDLE=0, PLAY=1, DYING=2, OVER=3) and the BCD digit type SHALL live in the shared game_pkg, reused by the renderer.
REQ-021 The BCD score counter with saturation SHALL be a sub-module, bcd_score_cnt, instanced once; best-compare stays in the top.

Verification
REQ-022 Reset, one flap_req, one frame_tick -> state PLAY, new_game one pulse, flap_evt 0, world_en 1.
REQ-023 PLAY, flap_req 5 cycles before frame_tick -> flap_evt high exactly on the frame_tick cycle, once; two flap_reqs in one frame -> one flap_evt.
REQ-024 PLAY, 12 pipe_pass pulses, collision at next frame_tick -> score 012, DYING, world_en 0, bird_en 1; after 60 frame_ticks state OVER, best 012.
REQ-025 OVER, flap at frame 10 -> stays OVER; flap at frame 31 -> PLAY, new_game pulse, score 000, best 012.
REQ-026 Score 998 plus 3 pipe_pass -> 999 held; jb0 held high 1000 cycles -> one flap only.
REQ-027 rst_n low during DYING -> state IDLE immediately, score and best 000, no new_game after release.
